// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way fixed/round-robin arbiter with registered one-hot grant; optional hold timeout via ARB_TIMEOUT_EN
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_mode,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_id,
  output logic       o_v,
  output logic       o_to
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     r_state, w_state;
  logic [3:0] r_gnt, w_gnt;
  logic [1:0] r_id, w_id, r_last, w_last, w_fix, w_rr, w_win;
  logic       r_to, w_to, w_arb;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt, w_cnt;
`else
  logic       w_unused_max;
  assign w_unused_max = ^MAX_HOLD;
`endif
  assign o_gnt    = r_gnt;
  assign o_gnt_id = r_id;
  assign o_v      = |r_gnt;
  assign o_to     = r_to;
  // winner candidates: highest index, or first set bit after LAST (descending loop leaves the nearest)
  always_comb begin
    w_fix = i_req[3] ? 2'd3 : i_req[2] ? 2'd2 : i_req[1] ? 2'd1 : 2'd0;
    w_rr  = r_last;
    for (int k = 3; k >= 0; k--)
      if (i_req[r_last + 2'(k + 1)]) w_rr = r_last + 2'(k + 1);
    w_win = i_mode ? w_rr : w_fix;
    w_arb = (r_state == IDLE) || !i_req[r_id];
  end
  // next state: arbitrate when idle or owner released, otherwise hold (and count toward forced release)
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_id    = r_id;
    w_last  = r_last;
    w_to    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_cnt   = r_cnt + 8'd1;
`endif
    if (w_arb) begin
      w_state = |i_req ? GRANT : IDLE;
      w_gnt   = |i_req ? 4'(1) << w_win : 4'b0000;
      w_id    = |i_req ? w_win : 2'd0;
      w_last  = |i_req ? w_win : r_last;
`ifdef ARB_TIMEOUT_EN
      w_cnt   = 8'd0;
`endif
    end
`ifdef ARB_TIMEOUT_EN
    else if (r_cnt == 8'(MAX_HOLD - 1)) begin
      w_state = IDLE;
      w_gnt   = 4'b0000;
      w_id    = 2'd0;
      w_to    = 1'b1;
      w_cnt   = 8'd0;
    end
`endif
  end
  // state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_id    <= 2'd0;
      r_last  <= 2'd3;
      r_to    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= 8'd0;
`endif
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_id    <= w_id;
      r_last  <= w_last;
      r_to    <= w_to;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= w_cnt;
`endif
    end
  end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed plus random stimulus checked against a behavioural arbiter model
module tb_rr_arbiter4;
  localparam int MH = 4;
  logic       clk = 1'b0, rst = 1'b1, mode = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       v, to;
  int n_chk = 0, n_err = 0;
  int m_own = -1, m_last = 3, m_cnt = 0, m_to = 0;

  rr_arbiter4 #(.MAX_HOLD(MH)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_mode(mode),
    .o_gnt(gnt), .o_gnt_id(gnt_id), .o_v(v), .o_to(to)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input logic md, input int last);
    if (!md) begin
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model(input logic [3:0] r, input logic md, input logic rs);
    int w;
    if (rs) begin
      m_own = -1; m_last = 3; m_cnt = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_own < 0 || !r[m_own]) begin
      w = pick(r, md, m_last);
      m_own = w;
      m_cnt = 0;
      if (w >= 0) m_last = w;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == MH - 1) begin
        m_own = -1; m_cnt = 0; m_to = 1;
      end else m_cnt++;
`else
      m_cnt++;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic md, input logic rs);
    req = r; mode = md; rst = rs;
    @(posedge clk);
    model(r, md, rs);
    #1;
    chk("gnt", 32'(gnt), m_own < 0 ? 32'd0 : 32'd1 << m_own);
    chk("gnt_id", 32'(gnt_id), m_own < 0 ? 32'd0 : 32'(m_own));
    chk("v", 32'(v), 32'(m_own >= 0));
    chk("to", 32'(to), 32'(m_to));
  endtask

  initial begin
    logic [3:0] r;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    chk("fixed_first", 32'(gnt), 32'h4);
    step(4'b0001, 1'b0, 1'b0);
    chk("fixed_release", 32'(gnt), 32'h1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("rr_order", 32'(gnt_id), 32'(i % 4));
      step(4'b1111, 1'b1, 1'b0);
      step(4'b1111 & ~gnt, 1'b1, 1'b0);
    end
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(i % 2 ? 4'b0010 : 4'b1010, 1'b0, 1'b0);
      chk("hold_ignore", 32'(gnt), 32'h2);
    end
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    chk("rst_mid", 32'(gnt), 32'h0);
    step(4'b1111, 1'b1, 1'b0);
    chk("rst_rr_first", 32'(gnt_id), 32'h0);
    for (int i = 0; i < 600; i++) begin
      r = 4'(i % 7 == 0 ? $urandom : (32'(req) ^ (($urandom_range(0, 5) == 0) ? 32'(1) << $urandom_range(0, 3) : 32'd0)));
      step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester bus arbiter that shares one downstream resource (e.g. a shared 2-bit result bus or display driver) between requesters REQ[3:0]. Each arbitration picks one winner using either fixed priority or round-robin priority. Fixed priority means the highest index wins, the same rule as the team's 4-to-2 priority encoder. The winner holds a registered one-hot grant until it drops its request. An optional hold-limit timer forces a release.

## Interface
- MAX_HOLD, 8: grant cycles allowed before a forced release (legal range 2..255); used only when the timeout feature is compiled in.
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  4  request lines; REQ[i]=1 means requester i wants the resource.
- MODE  input  1  0 = fixed priority (3 > 2 > 1 > 0), 1 = round-robin; sampled only at arbitration edges.
- GNT  output  4  registered one-hot grant; at most one bit set.
- GNT_ID  output  2  binary index of the current grant; 2'b00 when V=0.
- V  output  1  grant valid; equals |GNT.
- TO  output  1  one-cycle pulse on a forced release; constant 0 when the timeout feature is compiled out.

## Operation
- Two states:
  - IDLE: no grant held.
  - GRANT: grant held by index ID.
- Arbitration edge: any edge in IDLE, or any edge in GRANT where REQ[ID]=0.
- Winner selection at an arbitration edge:
  - MODE=0: highest set index of REQ.
  - MODE=1: first set bit scanning upward from (LAST+1) mod 4, wrapping 3→0. LAST is the index of the most recent grant.
- IDLE transitions:
  - REQ=4'b0000: stay IDLE; GNT=0, V=0, GNT_ID=0.
  - Otherwise: go to GRANT; GNT=onehot(winner), GNT_ID=winner, V=1, LAST←winner.
- GRANT transitions:
  - REQ[ID]=1: hold GNT, GNT_ID and V unchanged. Changes on other REQ bits are ignored.
  - REQ[ID]=0 with other requests pending: re-arbitrate on the same edge. The new grant appears with no dead cycle, and LAST is updated.
  - REQ[ID]=0 with no other requests: go to IDLE; outputs return to zero.
- The requester that just released is legal to win again in fixed mode. In round-robin mode it is lowest priority in the next scan.
- A MODE change while in GRANT has no effect until the next arbitration edge.
- Reset values: GNT=4'b0000, GNT_ID=2'b00, V=0, TO=0, state IDLE, LAST=2'd3 (the first round-robin scan starts at index 0), hold counter=0.
- Asserting RST during GRANT clears all state at that edge; nothing else persists.

## Timing
- Grant latency: REQ sampled at edge k; GNT valid during the cycle after edge k.
- Release latency: REQ[ID] seen low at edge k; GNT updates at edge k (new winner or zero).
- Hold counter: cleared at every new grant; increments each edge the grant is held.
- Forced release (feature compiled in):
  - Trigger: counter = MAX_HOLD-1 and REQ[ID] still 1, i.e. MAX_HOLD cycles of grant.
  - Response at that edge: go to IDLE, GNT=0, V=0, TO=1 for one cycle.
  - A normal arbitration follows on the next edge, so there is exactly one dead cycle.
- Simultaneous events: if REQ[ID] drops on the same edge the timeout would fire, the normal release wins and TO stays 0.

## Configuration
- ARB_TIMEOUT_EN defined:
  - Hold counter and forced release are compiled in.
  - TO pulses as described under Timing.
  - MAX_HOLD is active.
- ARB_TIMEOUT_EN undefined:
  - No counter logic is built.
  - A grant is held indefinitely while REQ[ID]=1.
  - TO is tied to 0; MAX_HOLD is ignored.

## Test plan
- Reset then idle: RST=1 for 2 cycles, REQ=4'b0000 → GNT=0, GNT_ID=0, V=0, TO=0 on every cycle.
- Fixed priority: MODE=0, REQ=4'b0101 → next cycle GNT=4'b0100, GNT_ID=2. Drop REQ[2] → on that same edge GNT=4'b0001, GNT_ID=0.
- Round-robin fairness: MODE=1, REQ=4'b1111 held high, each winner drops its REQ bit for one cycle after 2 cycles of grant → grant order 0,1,2,3,0.
- Hold and ignore: grant held by 1, REQ toggles 4'b0010↔4'b1010 for 5 cycles → GNT stays 4'b0010 throughout.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): REQ=4'b1000 constant → GNT=4'b1000 for 4 cycles, then one cycle GNT=0 with TO=1, then GNT=4'b1000 again. Without the macro → GNT stays 4'b1000 and TO stays 0.
- Reset mid-grant: grant held by 2, RST=1 for one edge → all outputs 0. After reset release with MODE=1, REQ=4'b1111 → first grant is index 0.
